alu_issue_seq: RTL and testbench
================================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 32, cycles alu_signal/operands are held for MULTU; legal range 2..63.
REQ-002 Parameter ALU_LAT, default 1, cycles the downstream ALU needs after alu_signal settles; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  instruction/operand bundle valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 instr  input  32  R-type word; opcode [31:26], shamt [10:6], funct [5:0].
REQ-008 rs_val  input  32  rs register value.
REQ-009 rt_val  input  32  rt register value.
REQ-010 alu_dataA  output  32  operand A to the ALU stage.
REQ-011 alu_dataB  output  32  operand B to the ALU stage.
REQ-012 alu_signal  output  6  funct code to the ALU stage.
REQ-013 alu_result  input  32  result returned by the ALU stage.
REQ-014 out_valid  output  1  response valid.
REQ-015 out_ready  input  1  consumer accepts response.
REQ-016 out_data  output  32  captured result.
REQ-017 out_err  output  1  response is for an illegal instruction.

Function
REQ-018 Legal functs SHALL be AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18, with opcode 0; anything else is illegal.
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; in_ready SHALL be 1 only in IDLE.
REQ-020 Accept SHALL occur on an edge with in_valid=1 and in_ready=1 (cycle T); in_valid is ignored otherwise.
REQ-021 Operand mapping, registered at accept: AND/OR/ADD/SUB/SLT/MULTU: A=rs_val, B=rt_val; SRL: A=rt_val, B={27'b0,shamt}; MFHI/MFLO: A=0, B=0.
REQ-022 Legal accept SHALL move IDLE->EXEC; alu_signal=funct and operands valid from cycle T+1.
REQ-023 EXEC SHALL last W cycles (T+1..T+W), W=ALU_LAT+1 for non-MULTU, W=MUL_CYCLES for MULTU, counted by a 6-bit down-counter.
REQ-024 alu_result SHALL be sampled into out_data on the edge ending cycle T+W; MULTU SHALL instead load out_data=0.
REQ-025 EXEC->RESP after W cycles; out_valid=1 from cycle T+W+1, out_err=0.
REQ-026 Illegal accept SHALL go IDLE->RESP directly: out_valid=1 at T+1, out_err=1, out_data=0, alu_signal stays 0.
REQ-027 alu_signal SHALL be 0 in IDLE and RESP; alu_dataA/alu_dataB hold last values outside EXEC.
REQ-028 In RESP, out_valid, out_data, out_err SHALL stay stable until an edge with out_ready=1, then RESP->IDLE and out_valid=0 next cycle.
REQ-029 out_ready=1 outside RESP SHALL have no effect; in_valid during EXEC/RESP SHALL not be captured.
REQ-030 Default throughput: one non-MULTU op per 4 cycles with out_ready tied high.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, counter=0, in_ready=1 (combinationally from state), out_valid=0, out_err=0, out_data=0, alu_signal=0, alu_dataA=0, alu_dataB=0.
REQ-032 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response is ever emitted for it.
REQ-033 First accept after reset release SHALL be possible on the first rising edge with reset=1.

Verification
REQ-034 ADD, rs=5, rt=7, alu_result=12 returned, out_ready=1 -> alu_signal=32 at T+1..T+2, out_valid=1 out_data=12 at T+3, IDLE at T+4.
REQ-035 SRL, instr shamt=4, rt=0xF0, rs=0xDEAD -> alu_dataA=0xF0, alu_dataB=4, alu_signal=2; response with returned alu_result.
REQ-036 MULTU, rs=3, rt=4 -> alu_signal=25 for 32 cycles T+1..T+32, out_valid at T+33 with out_data=0; in_valid pulses during wait ignored.
REQ-037 instr funct=7 (or opcode=1) -> out_valid=1, out_err=1, out_data=0 at T+1; alu_signal never nonzero.
REQ-038 SUB response with out_ready=0 for 5 cycles -> out_valid/out_data stable 5 cycles, IDLE one cycle after out_ready=1 edge.
REQ-039 reset=0 at T+10 of MULTU -> all outputs zero asynchronously, no response after release, next ADD completes normally.

Source files
------------

// File: rtl/alu_issue_seq_if.sv
// Bundle, ALU-stage and response signals of the ALU issue sequencer.
// The slave modport is the sequencer side; the master modport is its environment.
interface alu_issue_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  modport slave (
    input  in_valid, instr, rs_val, rt_val, alu_result, out_ready,
    output in_ready, alu_dataA, alu_dataB, alu_signal, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, instr, rs_val, rt_val, alu_result, out_ready,
    input  in_ready, alu_dataA, alu_dataB, alu_signal, out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issues one R-type instruction at a time to an external ALU stage, holds the
// operands for the op's latency window and returns the captured result.
module alu_issue_seq #(
  parameter int MUL_CYCLES = 32,
  parameter int ALU_LAT    = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_seq_if.slave bus
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  // The counter holds the remaining EXEC cycles minus one.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] ALU_LOAD = 6'(ALU_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state, state_nxt;
  logic [5:0]  count;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        legal;
  logic        accept;
  logic        unused_bits;

  assign funct       = bus.instr[5:0];
  assign shamt       = bus.instr[10:6];
  assign unused_bits = ^bus.instr[25:11];

  always_comb begin
    legal = 1'b0;
    if (bus.instr[31:26] == 6'd0) begin
      case (funct)
        F_AND, F_OR, F_ADD, F_SUB, F_SLT,
        F_SRL, F_MULTU, F_MFHI, F_MFLO: legal = 1'b1;
        default:                        legal = 1'b0;
      endcase
    end
  end

  assign accept       = bus.in_valid && (state == IDLE);
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt takes a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)          state_nxt = legal ? EXEC : RESP;
      EXEC: if (count == 6'd0)   state_nxt = RESP;
      RESP: if (bus.out_ready)   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset asynchronously and updated with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      bus.alu_signal <= '0;
      bus.alu_dataA  <= '0;
      bus.alu_dataB  <= '0;
      bus.out_data   <= '0;
      bus.out_err    <= 1'b0;
    end else if (accept) begin
      bus.out_err <= !legal;
      if (legal) begin
        bus.alu_signal <= funct;
        count          <= (funct == F_MULTU) ? MUL_LOAD : ALU_LOAD;
        case (funct)
          F_SRL: begin
            bus.alu_dataA <= bus.rt_val;
            bus.alu_dataB <= {27'd0, shamt};
          end
          F_MFHI, F_MFLO: begin
            bus.alu_dataA <= '0;
            bus.alu_dataB <= '0;
          end
          default: begin
            bus.alu_dataA <= bus.rs_val;
            bus.alu_dataB <= bus.rt_val;
          end
        endcase
      end else begin
        bus.out_data <= '0;
      end
    end else if (state == EXEC) begin
      if (count == 6'd0) begin
        // The multiplier result lives in HI/LO downstream; the response carries no data.
        bus.out_data   <= (bus.alu_signal == F_MULTU) ? 32'd0 : bus.alu_result;
        bus.alu_signal <= '0;
      end else begin
        count <= count - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq: a behavioural ALU with ALU_LAT latency
// answers the DUT, and each op's timing and response follow from its funct.
module tb_alu_issue_seq;

  localparam int MUL_CYCLES = 32;
  localparam int ALU_LAT    = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  alu_issue_seq_if bus();

  alu_issue_seq #(.MUL_CYCLES(MUL_CYCLES), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:    return a >> b[4:0];
      6'd16:   return 32'hA5A5_0001;
      6'd18:   return 32'h5A5A_0002;
      6'd25:   return a * b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit is_legal(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) &&
           (ins[5:0] inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18});
  endfunction

  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] sh, input logic [5:0] f);
    logic [14:0] regs;
    regs = 15'($urandom);
    return {op, regs, sh, f};
  endfunction

  // Downstream ALU: the result is only meaningful once the funct has been stable ALU_LAT cycles.
  int          age   = 0;
  logic [31:0] noise = 32'h0;
  always @(posedge clk) begin
    age   <= (bus.alu_signal == 6'd0) ? 0 : age + 1;
    noise <= $urandom;
  end
  assign bus.alu_result = (bus.alu_signal != 6'd0 && age >= ALU_LAT)
                          ? alu_ref(bus.alu_signal, bus.alu_dataA, bus.alu_dataB) : noise;

  task automatic junk_inputs();
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.instr     = $urandom;
    bus.rs_val    = $urandom;
    bus.rt_val    = $urandom;
  endtask

  // Called at a negedge while idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input int hold);
    logic [5:0]  f;
    logic [31:0] ea, eb, ed;
    bit          legal;
    int          w;
    f     = ins[5:0];
    legal = is_legal(ins);
    if (f == 6'd2) begin
      ea = rt; eb = {27'd0, ins[10:6]};
    end else if (f == 6'd16 || f == 6'd18) begin
      ea = 32'd0; eb = 32'd0;
    end else begin
      ea = rs; eb = rt;
    end
    w  = (f == 6'd25) ? MUL_CYCLES : ALU_LAT + 1;
    ed = (!legal || f == 6'd25) ? 32'd0 : alu_ref(f, ea, eb);

    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    @(negedge clk);
    junk_inputs();
    if (legal) begin
      for (int c = 1; c <= w; c++) begin
        check("exec_out_valid", 32'(bus.out_valid), 32'd0);
        check("exec_in_ready", 32'(bus.in_ready), 32'd0);
        check("exec_alu_signal", 32'(bus.alu_signal), 32'(f));
        if (c == 1) begin
          check("alu_dataA", bus.alu_dataA, ea);
          check("alu_dataB", bus.alu_dataB, eb);
        end
        bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        junk_inputs();
      end
    end
    check("resp_out_valid", 32'(bus.out_valid), 32'd1);
    check("resp_out_err", 32'(bus.out_err), legal ? 32'd0 : 32'd1);
    check("resp_out_data", bus.out_data, ed);
    check("resp_alu_signal", 32'(bus.alu_signal), 32'd0);
    check("resp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      junk_inputs();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_data", bus.out_data, ed);
      check("hold_out_err", 32'(bus.out_err), legal ? 32'd0 : 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("done_out_valid", 32'(bus.out_valid), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
    check({tag, "_alu_signal"}, 32'(bus.alu_signal), 32'd0);
    check({tag, "_alu_dataA"}, bus.alu_dataA, 32'd0);
    check({tag, "_alu_dataB"}, bus.alu_dataB, 32'd0);
  endtask

  initial begin
    logic [5:0] legal_f [9];
    logic [5:0] f;
    logic [5:0] op;
    legal_f = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18};

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // First edge after release accepts: ADD 5+7.
    run_op(mk_instr(6'd0, 5'd0, 6'd32), 32'd5, 32'd7, 0);
    run_op(mk_instr(6'd0, 5'd4, 6'd2), 32'hDEAD, 32'hF0, 1);
    run_op(mk_instr(6'd0, 5'd0, 6'd25), 32'd3, 32'd4, 0);
    run_op(mk_instr(6'd0, 5'd0, 6'd7), 32'd1, 32'd2, 0);
    run_op(mk_instr(6'd1, 5'd0, 6'd32), 32'd1, 32'd2, 2);
    run_op(mk_instr(6'd0, 5'd0, 6'd34), 32'd100, 32'd1, 5);
    run_op(mk_instr(6'd0, 5'd0, 6'd42), 32'hFFFF_FFFF, 32'd1, 0);

    // Reset in the tenth EXEC cycle of a MULTU discards it.
    bus.in_valid = 1'b1;
    bus.instr    = mk_instr(6'd0, 5'd0, 6'd25);
    bus.rs_val   = 32'd3;
    bus.rt_val   = 32'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_exec_alu_signal", 32'(bus.alu_signal), 32'd25);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("post_rst_no_resp", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    run_op(mk_instr(6'd0, 5'd0, 6'd32), 32'd20, 32'd22, 0);

    for (int n = 0; n < 80; n++) begin
      int k;
      k  = $urandom_range(0, 9);
      op = 6'd0;
      if (k < 9) begin
        f = legal_f[k];
      end else begin
        f = 6'($urandom);
        if ($urandom_range(0, 1) == 1) op = 6'($urandom_range(1, 63));
      end
      run_op(mk_instr(op, 5'($urandom), f), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
